// File: rtl/tracker_pkg.sv
// Shared types and helpers for the two-axis sweep tracker.
package tracker_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWEEP_BASE = 2'd1,
        SWEEP_ARM  = 2'd2,
        DONE       = 2'd3
    } state_e;

    // Number of positions k*step visited per axis while k*step <= angle_max.
    function automatic int unsigned num_positions(input int unsigned angle_max,
                                                  input int unsigned step);
        return angle_max / step + 1;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable settle down-counter; strobes sample_c on the last cycle of each position.
module settle_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         sample_c
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_q, period_d;

    // The period is captured on load so the count restarts identically for every position.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        if (load) begin
            period_d = load_val;
            cnt_d    = load_val - W'(1);
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? (period_q - W'(1)) : (cnt_q - W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    assign sample_c = en && !load && (cnt_q == '0);

endmodule

// File: rtl/sweep_tracker.sv
// Two-axis sun-finding sweep: scan base, park at the brightest angle, scan arm, park at the peak.
module sweep_tracker
    import tracker_pkg::*;
#(
    parameter int unsigned ANGLE_W   = 8,
    parameter int unsigned ANGLE_MAX = 180,
    parameter int unsigned STEP      = 1,
    parameter int unsigned LDR_W     = 10,
    parameter int unsigned SETTLE_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle,
    input  logic [LDR_W-1:0]    ldr,
    output logic [ANGLE_W-1:0]  base,
    output logic [ANGLE_W-1:0]  arm,
    output logic                busy,
    output logic                status,
    output logic                done,
    output logic [LDR_W-1:0]    peak
);

    localparam int unsigned NEXT_W = ANGLE_W + 1;

    state_e               state_q, state_d;
    logic [ANGLE_W-1:0]   base_q, base_d;
    logic [ANGLE_W-1:0]   arm_q, arm_d;
    logic [LDR_W-1:0]     best_val_q, best_val_d;
    logic [ANGLE_W-1:0]   best_ang_q, best_ang_d;
    logic [LDR_W-1:0]     peak_q, peak_d;
    logic                 busy_q, busy_d;
    logic                 status_q, status_d;
    logic                 done_q, done_d;

    logic                 tmr_load_c;
    logic                 tmr_en_c;
    logic                 sample_c;
    logic [SETTLE_W-1:0]  settle_eff_c;
    logic [ANGLE_W-1:0]   cur_ang_c;
    logic [NEXT_W-1:0]    next_ang_c;
    logic                 last_c;
    logic                 better_c;
    logic [LDR_W-1:0]     samp_val_c;
    logic [ANGLE_W-1:0]   samp_ang_c;

    assign settle_eff_c = (settle == '0) ? SETTLE_W'(1) : settle;
    assign tmr_en_c     = (state_q == SWEEP_BASE) || (state_q == SWEEP_ARM);

    settle_timer #(
        .W (SETTLE_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_c),
        .en       (tmr_en_c),
        .load_val (settle_eff_c),
        .sample_c (sample_c)
    );

    // Stepping and best tracking are shared; the active axis selects which angle moves.
    assign cur_ang_c  = (state_q == SWEEP_ARM) ? arm_q : base_q;
    assign next_ang_c = NEXT_W'(cur_ang_c) + NEXT_W'(STEP);
    assign last_c     = next_ang_c > NEXT_W'(ANGLE_MAX);
    assign better_c   = ldr > best_val_q;
    assign samp_val_c = better_c ? ldr : best_val_q;
    assign samp_ang_c = better_c ? cur_ang_c : best_ang_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        arm_d      = arm_q;
        best_val_d = best_val_q;
        best_ang_d = best_ang_q;
        peak_d     = peak_q;
        busy_d     = busy_q;
        status_d   = status_q;
        done_d     = 1'b0;
        tmr_load_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = SWEEP_BASE;
                    base_d     = '0;
                    arm_d      = '0;
                    best_val_d = '0;
                    best_ang_d = '0;
                    status_d   = 1'b0;
                    busy_d     = 1'b1;
                    tmr_load_c = 1'b1;
                end
            end
            SWEEP_BASE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (sample_c) begin
                    best_val_d = samp_val_c;
                    best_ang_d = samp_ang_c;
                    if (last_c) begin
                        state_d    = SWEEP_ARM;
                        base_d     = samp_ang_c;
                        arm_d      = '0;
                        best_val_d = '0;
                        best_ang_d = '0;
                    end else begin
                        base_d = ANGLE_W'(next_ang_c);
                    end
                end
            end
            SWEEP_ARM: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (sample_c) begin
                    best_val_d = samp_val_c;
                    best_ang_d = samp_ang_c;
                    if (last_c) begin
                        state_d  = DONE;
                        arm_d    = samp_ang_c;
                        peak_d   = samp_val_c;
                        status_d = 1'b1;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        arm_d = ANGLE_W'(next_ang_c);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            arm_q      <= '0;
            best_val_q <= '0;
            best_ang_q <= '0;
            peak_q     <= '0;
            busy_q     <= 1'b0;
            status_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            arm_q      <= arm_d;
            best_val_q <= best_val_d;
            best_ang_q <= best_ang_d;
            peak_q     <= peak_d;
            busy_q     <= busy_d;
            status_q   <= status_d;
            done_q     <= done_d;
        end
    end

    assign base   = base_q;
    assign arm    = arm_q;
    assign busy   = busy_q;
    assign status = status_q;
    assign done   = done_q;
    assign peak   = peak_q;

endmodule
